bcd_to_eight_bit_binary: RTL and testbench
==========================================

# bcd_to_eight_bit_binary

Sequential three-digit BCD to 8-bit binary converter, the inverse of the eight-bit binary-to-BCD converter in the I2C master / LCD temperature-sensor design. It converts operator-entered decimal values, such as a temperature set-point typed as hundreds/tens/ones digits, into the 8-bit binary form compared against sensor readings or written to the slave over I2C. It uses repeated addition rather than a multiplier. It reports invalid-digit and out-of-range conditions, uses an Enable/Done handshake, and converts in a data-dependent number of cycles.

## Interface
Parameters: none.
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high reset
- Enable  input  1  start pulse; sampled on rising clk; restarts conversion from any state
- BCDDigitHundreds  input  4  hundreds digit, legal 0–9
- BCDDigitTens  input  4  tens digit, legal 0–9
- BCDDigitOnes  input  4  ones digit, legal 0–9
- BinaryOutput  output  8  result; saturates at 255
- Done  output  1  level; high when result valid; held until next Enable or reset
- Busy  output  1  high while a conversion is in progress (state ≠ IDLE)
- Error  output  1  a latched digit was > 9; valid with Done
- Overflow  output  1  decimal value > 255; valid with Done

## Operation
- Internal registers: latched digits hcnt, tcnt, ones (4 b each) and a 10-bit accumulator acc (max 999, never wraps).
- States: IDLE, HUND, TENS, ONES, FINISH.
- Enable high at an edge, any state:
  - latch all three digits; acc←0.
  - BinaryOutput←0, Done←0, Error←0, Overflow←0.
  - If any digit > 9: Error←1, next state FINISH.
  - Otherwise next state HUND.
- HUND: if hcnt≠0, acc←acc+100 and hcnt←hcnt−1; else go to TENS.
- TENS: if tcnt≠0, acc←acc+10 and tcnt←tcnt−1; else go to ONES.
- ONES: acc←acc+ones; go to FINISH.
- FINISH:
  - Done←1.
  - If Error: BinaryOutput←0, Overflow←0.
  - Else if acc>255: BinaryOutput←255, Overflow←1.
  - Else: BinaryOutput←acc[7:0].
  - Go to IDLE.
- IDLE: hold all outputs; Done stays high after a completed conversion.
- Busy is combinational from state: 1 in HUND/TENS/ONES/FINISH, 0 in IDLE.
- Input digits are don't-care after the Enable edge; changes to them mid-conversion have no effect.

## Timing
- Reset values: state IDLE, acc 0, BinaryOutput 0, Done 0, Busy 0, Error 0, Overflow 0. Reset takes effect immediately and asynchronously, including mid-conversion.
- Latency for legal digits (edges after the Enable edge until Done is high): H+T+4. Examples: 000 → 4; 255 → 11; 999 → 22.
- Latency for an invalid digit: Done high after 1 edge.
- Enable held high for N edges: each edge re-latches and restarts. Latency counts from the last high edge, and Done stays 0 throughout.
- Enable asserted on the same edge that FINISH would complete: Enable wins, Done stays 0, and the new conversion starts.
- Overflow boundary: 255 gives Overflow 0; 256 gives Overflow 1 with BinaryOutput 255.
- Error has priority over Overflow; both are never 1 together.
- BinaryOutput, Done, Error and Overflow change only at the FINISH edge, at the Enable edge, or on reset.

## Test plan
- Reset, then digits 0/0/0 with a 1-cycle Enable → Done at edge 4, BinaryOutput 0x00, Busy high for edges 1–4, Error 0, Overflow 0.
- Digits 2/5/5 → Done after 11 edges, BinaryOutput 0xFF, Overflow 0. Repeat with 1/2/8 → 0x80 after 7 edges.
- Digits 2/5/6 → BinaryOutput 0xFF, Overflow 1. Digits 9/9/9 → 0xFF, Overflow 1, Done after 22 edges.
- Digits 1/0xA/3 → Done after 1 edge, Error 1, BinaryOutput 0, Overflow 0. Digit value 0xF in the ones position gives the same result.
- Start 9/9/9; at edge 5 re-assert Enable with 0/4/2 → Done 0 until 8 edges after the second Enable, BinaryOutput 0x2A, Overflow 0.
- Start 2/0/0; assert reset asynchronously between edges 2 and 3 → all outputs 0 immediately, state IDLE. A subsequent Enable with 0/0/7 gives 0x07 after 4 edges.

Source files
------------

// File: rtl/bcd_to_eight_bit_binary.sv
// Three-digit BCD to 8-bit binary converter built from repeated addition.
// Enable restarts from any state; Done holds the result until the next Enable.
module bcd_to_eight_bit_binary (
  input  logic       clk,
  input  logic       reset,
  input  logic       Enable,
  input  logic [3:0] BCDDigitHundreds,
  input  logic [3:0] BCDDigitTens,
  input  logic [3:0] BCDDigitOnes,
  output logic [7:0] BinaryOutput,
  output logic       Done,
  output logic       Busy,
  output logic       Error,
  output logic       Overflow
);

  typedef enum logic [2:0] {IDLE, HUND, TENS, ONES, FINISH} state_t;

  // Handshake: a high Enable sampled on a rising edge starts a conversion and
  // clears Done; Done rises on the FINISH edge and stays high until the next Enable.
  state_t     state, state_next;
  logic [3:0] hcnt, tcnt, ones;
  logic [9:0] acc;
  logic       digit_bad;

  assign digit_bad = (BCDDigitHundreds > 4'd9) || (BCDDigitTens > 4'd9) ||
                     (BCDDigitOnes > 4'd9);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    Busy       = (state != IDLE);
    if (Enable) begin
      state_next = digit_bad ? FINISH : HUND;
    end else begin
      case (state)
        HUND:    if (hcnt == 4'd0) state_next = TENS;
        TENS:    if (tcnt == 4'd0) state_next = ONES;
        ONES:    state_next = FINISH;
        FINISH:  state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt         <= 4'd0;
      tcnt         <= 4'd0;
      ones         <= 4'd0;
      acc          <= 10'd0;
      BinaryOutput <= 8'd0;
      Done         <= 1'b0;
      Error        <= 1'b0;
      Overflow     <= 1'b0;
    end else if (Enable) begin
      hcnt         <= BCDDigitHundreds;
      tcnt         <= BCDDigitTens;
      ones         <= BCDDigitOnes;
      acc          <= 10'd0;
      BinaryOutput <= 8'd0;
      Done         <= 1'b0;
      Error        <= digit_bad;
      Overflow     <= 1'b0;
    end else begin
      case (state)
        HUND: if (hcnt != 4'd0) begin
          acc  <= acc + 10'd100;
          hcnt <= hcnt - 4'd1;
        end
        TENS: if (tcnt != 4'd0) begin
          acc  <= acc + 10'd10;
          tcnt <= tcnt - 4'd1;
        end
        ONES: acc <= acc + {6'd0, ones};
        FINISH: begin
          Done <= 1'b1;
          // Error takes priority so Error and Overflow are never both set.
          if (Error) begin
            BinaryOutput <= 8'd0;
            Overflow     <= 1'b0;
          end else if (acc > 10'd255) begin
            BinaryOutput <= 8'hFF;
            Overflow     <= 1'b1;
          end else begin
            BinaryOutput <= acc[7:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_eight_bit_binary.sv
// Self-checking bench for bcd_to_eight_bit_binary: directed corner cases plus
// random digit triples checked against an arithmetic reference model.
module tb_bcd_to_eight_bit_binary;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       Enable = 1'b0;
  logic [3:0] BCDDigitHundreds = 4'd0;
  logic [3:0] BCDDigitTens = 4'd0;
  logic [3:0] BCDDigitOnes = 4'd0;
  logic [7:0] BinaryOutput;
  logic       Done, Busy, Error, Overflow;

  int checks = 0;
  int failures = 0;

  bcd_to_eight_bit_binary dut (
    .clk(clk), .reset(reset), .Enable(Enable),
    .BCDDigitHundreds(BCDDigitHundreds), .BCDDigitTens(BCDDigitTens),
    .BCDDigitOnes(BCDDigitOnes), .BinaryOutput(BinaryOutput), .Done(Done),
    .Busy(Busy), .Error(Error), .Overflow(Overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: decimal value, saturation and latency from plain arithmetic.
  task automatic model(input int h, input int t, input int o,
                       output int val, output int lat, output int err, output int ovf);
    int v;
    if (h > 9 || t > 9 || o > 9) begin
      err = 1; ovf = 0; val = 0; lat = 1;
    end else begin
      v   = 100 * h + 10 * t + o;
      err = 0;
      ovf = (v > 255) ? 1 : 0;
      val = (v > 255) ? 255 : v;
      lat = h + t + 4;
    end
  endtask

  task automatic set_digits(input int h, input int t, input int o);
    BCDDigitHundreds = 4'(h);
    BCDDigitTens     = 4'(t);
    BCDDigitOnes     = 4'(o);
  endtask

  // Drives a one-edge Enable pulse and checks the cleared outputs after it.
  task automatic start(input int h, input int t, input int o);
    int val, lat, err, ovf;
    model(h, t, o, val, lat, err, ovf);
    set_digits(h, t, o);
    Enable = 1'b1;
    @(posedge clk); #1;
    Enable = 1'b0;
    check("start_done", Done, 0);
    check("start_bin", BinaryOutput, 0);
    check("start_busy", Busy, 1);
    check("start_err", Error, err);
  endtask

  // Waits for Done (bounded), scrambling the inputs meanwhile, then checks results.
  task automatic finish_conv(input int h, input int t, input int o);
    int val, lat, err, ovf, n;
    model(h, t, o, val, lat, err, ovf);
    n = 0;
    while (!Done && n < 100) begin
      check("busy_run", Busy, 1);
      @(posedge clk); #1;
      n++;
      set_digits($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
    end
    check("done_seen", Done, 1);
    check("latency", n, lat);
    check("bin", BinaryOutput, val);
    check("err", Error, err);
    check("ovf", Overflow, ovf);
    check("busy_idle", Busy, 0);
    @(posedge clk); #1;
    check("done_hold", Done, 1);
    check("bin_hold", BinaryOutput, val);
  endtask

  task automatic conv(input int h, input int t, input int o);
    start(h, t, o);
    finish_conv(h, t, o);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_bin", BinaryOutput, 0);
    check("rst_done", Done, 0);
    check("rst_busy", Busy, 0);
    check("rst_err", Error, 0);
    check("rst_ovf", Overflow, 0);

    conv(0, 0, 0);
    conv(2, 5, 5);
    conv(1, 2, 8);
    conv(2, 5, 6);
    conv(9, 9, 9);
    conv(1, 10, 3);
    conv(0, 0, 15);

    // Restart mid-conversion: 999 interrupted at edge 5 by 042.
    start(9, 9, 9);
    repeat (4) begin
      @(posedge clk); #1;
      check("rs_done", Done, 0);
    end
    set_digits(0, 4, 2);
    Enable = 1'b1;
    @(posedge clk); #1;
    Enable = 1'b0;
    check("rs_done2", Done, 0);
    finish_conv(0, 4, 2);

    // Enable on the FINISH edge of a 000 conversion wins over completion.
    start(0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    set_digits(1, 2, 8);
    Enable = 1'b1;
    @(posedge clk); #1;
    Enable = 1'b0;
    check("fin_en_done", Done, 0);
    finish_conv(1, 2, 8);

    // Enable held for three edges: each edge restarts, Done stays low.
    set_digits(2, 5, 6);
    Enable = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("hold_done", Done, 0);
    end
    Enable = 1'b0;
    finish_conv(2, 5, 6);

    // Asynchronous reset mid-conversion.
    start(2, 0, 0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("arst_busy", Busy, 0);
    check("arst_done", Done, 0);
    check("arst_bin", BinaryOutput, 0);
    check("arst_err", Error, 0);
    check("arst_ovf", Overflow, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    check("arst_idle", Busy, 0);
    conv(0, 0, 7);

    // Random triples, mostly legal with occasional invalid digits.
    for (int i = 0; i < 40; i++) begin
      int h, t, o;
      h = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 9);
      t = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 9);
      o = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 9);
      conv(h, t, o);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
